tc_pl_bus_tx: RTL and testbench
===============================

// Module: tc_pl_bus_tx
// PURPOSE
//   PL-side transmit engine for the Tc bus link; produces tx_ting, tx_cmpt, txb_empty and txb_full for the bus status word.
//   PS writes bytes into an internal TX FIFO, then pulses tx_start; the engine drains the FIFO as serial 8N1 frames on txd.
//   Stops when the FIFO runs dry, then pulses tx_cmpt for the sticky completion flag in the status word.
// PARAMETERS
//   DEPTH    16   TX FIFO depth in bytes; power of two, >=2
//   CLK_DIV  868  clk cycles per serial bit; >=2 (868 = 115200 baud at 100 MHz)
// PORTS
//   clk        in   1   clock
//   rst        in   1   reset, synchronous, active-high
//   wr_en      in   1   push wr_data into TX FIFO this cycle
//   wr_data    in   8   byte to push
//   tx_start   in   1   single-cycle request to start draining FIFO
//   txd        out  1   serial line, idle high
//   tx_ting    out  1   high while a transmission burst is in progress
//   tx_cmpt    out  1   one-cycle pulse when a burst finishes (FIFO drained)
//   txb_empty  out  1   TX FIFO holds 0 bytes
//   txb_full   out  1   TX FIFO holds DEPTH bytes
//   wr_ovf     out  1   one-cycle pulse: wr_en while full, byte dropped
//   txb_level  out  $clog2(DEPTH)+1  current FIFO byte count
// BEHAVIOUR
//   Reset: txd=1, tx_ting=0, tx_cmpt=0, wr_ovf=0, txb_empty=1, txb_full=0, txb_level=0; FIFO pointers cleared; FSM=IDLE.
//   FIFO: registered flags/level, updated the cycle after the write/pop edge. Simultaneous push and pop keeps the level unchanged.
//   wr_en while txb_full: byte dropped, level unchanged, wr_ovf=1 next cycle. This applies even if a pop occurs the same cycle.
//   Pointers wrap modulo DEPTH; level range is 0..DEPTH.
//   FSM states: IDLE, LOAD, START, DATA, STOP.
//   IDLE: txd=1, tx_ting=0.
//     tx_start=1 with FIFO non-empty -> LOAD.
//     tx_start with FIFO empty -> ignored, no tx_cmpt.
//   LOAD (1 cycle): pop FIFO head into shift register, clear bit counter -> START. tx_ting=1 from the LOAD cycle onward.
//   START: txd=0 for CLK_DIV cycles -> DATA.
//   DATA: 8 bits LSB first, each CLK_DIV cycles -> STOP.
//   STOP: txd=1 for CLK_DIV cycles.
//     Then FIFO non-empty -> LOAD (bytes appended mid-burst join the burst).
//     Else -> IDLE with tx_cmpt=1 for exactly that cycle, and tx_ting=0 the same cycle.
//   Per-byte cost: 1 + 10*CLK_DIV cycles. txd is registered; no glitches between bits.
//   tx_start while tx_ting=1: ignored.
//   Bit timer: counts 0..CLK_DIV-1, reloads at every bit boundary.
//   Reset mid-frame: txd=1 next cycle, frame truncated, FIFO contents discarded, no tx_cmpt pulse.
// TESTING (CLK_DIV=4, DEPTH=4)
//   1. Reset, then idle 10 cycles -> txd=1, txb_empty=1, tx_ting=0, tx_cmpt never asserted.
//   2. Write 0xA5, tx_start -> txd: 0 (4 cyc), then 1,0,1,0,0,1,0,1 (4 cyc each), then 1 (4 cyc).
//      tx_ting high for 41 cycles; tx_cmpt single pulse as tx_ting falls; txb_empty=1 after pop.
//   3. Write 0x01,0x02,0x03,0x04 -> txb_full=1, level=4. 5th write 0xFF -> wr_ovf pulse, level stays 4.
//      tx_start -> 4 back-to-back frames (164 cycles), one tx_cmpt.
//   4. During frame of 0x11, write 0x22 and pulse tx_start mid-frame -> tx_start ignored.
//      0x22 sent in the same burst; single tx_cmpt after 82 cycles.
//   5. tx_start with empty FIFO -> tx_ting stays 0, no tx_cmpt. Push and pop in the same cycle at level 2 -> level stays 2.
//   6. Assert rst mid-DATA of 0x3C with 2 bytes queued -> next cycle txd=1, level=0, txb_empty=1, tx_ting=0, no tx_cmpt.

Source files
------------

// File: rtl/tc_pl_bus_tx_if.sv
// Tc bus link PL transmit port: PS-side byte writes and start request,
// serial line and status-word flags back.
interface tc_pl_bus_tx_if #(
   parameter int DEPTH = 16
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          wr_en;
   logic [7:0]    wr_data;
   logic          tx_start;
   logic          txd;
   logic          tx_ting;
   logic          tx_cmpt;
   logic          txb_empty;
   logic          txb_full;
   logic          wr_ovf;
   logic [LW-1:0] txb_level;

   modport master (
      output wr_en, wr_data, tx_start,
      input  txd, tx_ting, tx_cmpt,
      input  txb_empty, txb_full, wr_ovf, txb_level
   );

   modport slave (
      input  wr_en, wr_data, tx_start,
      output txd, tx_ting, tx_cmpt,
      output txb_empty, txb_full, wr_ovf, txb_level
   );
endinterface

// File: rtl/tc_pl_bus_tx.sv
// Tc bus link PL transmit engine: byte FIFO drained as 8N1 frames on txd,
// with burst-active and burst-complete flags for the status word.
module tc_pl_bus_tx #(
   parameter int DEPTH   = 16,
   parameter int CLK_DIV = 868
) (
   input  logic           clk,
   input  logic           rst,
   tc_pl_bus_tx_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic          empty_q;
   logic          full_q;
   logic          ovf_q;
   logic          push;
   logic          pop;

   state_t        state_q;
   logic [TW-1:0] tmr_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          txd_q;
   logic          ting_q;
   logic          cmpt_q;
   logic          tmr_done;

   // A write while full is dropped even if a pop frees a slot this cycle.
   assign push     = bus.wr_en && !full_q;
   assign pop      = (state_q == LOAD);
   assign tmr_done = (tmr_q == TW'(CLK_DIV - 1));

   always_comb begin
      level_d = level_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         level_q <= level_d;
         empty_q <= (level_d == '0);
         full_q  <= (level_d == LW'(DEPTH));
         ovf_q   <= bus.wr_en && full_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         ting_q  <= 1'b0;
         cmpt_q  <= 1'b0;
      end else begin
         cmpt_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.tx_start && !empty_q) begin
                  state_q <= LOAD;
                  ting_q  <= 1'b1;
               end
            end
            LOAD: begin
               shift_q <= mem_q[rptr_q];
               bit_q   <= '0;
               tmr_q   <= '0;
               txd_q   <= 1'b0;
               state_q <= START;
            end
            START: begin
               if (tmr_done) begin
                  tmr_q   <= '0;
                  txd_q   <= shift_q[0];
                  state_q <= DATA;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            DATA: begin
               if (tmr_done) begin
                  tmr_q   <= '0;
                  bit_q   <= bit_q + 1'b1;
                  shift_q <= shift_q >> 1;
                  if (bit_q == 3'd7) begin
                     txd_q   <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     txd_q <= shift_q[1];
                  end
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            STOP: begin
               if (tmr_done) begin
                  tmr_q <= '0;
                  // Bytes queued during the burst keep it going.
                  if (!empty_q) begin
                     state_q <= LOAD;
                  end else begin
                     state_q <= IDLE;
                     ting_q  <= 1'b0;
                     cmpt_q  <= 1'b1;
                  end
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.txd       = txd_q;
   assign bus.tx_ting   = ting_q;
   assign bus.tx_cmpt   = cmpt_q;
   assign bus.txb_empty = empty_q;
   assign bus.txb_full  = full_q;
   assign bus.wr_ovf    = ovf_q;
   assign bus.txb_level = level_q;
endmodule

// File: tb/tb_tc_pl_bus_tx.sv
// Bench for tc_pl_bus_tx: vector table, burst sequences and random
// traffic against a frame-timing reference model.
module tb_tc_pl_bus_tx;
   localparam int CD = 4;
   localparam int D  = 4;
   localparam int FR = 10 * CD;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   nprint = 0;

   tc_pl_bus_tx_if #(.DEPTH(D)) ifc ();

   tc_pl_bus_tx #(.DEPTH(D), .CLK_DIV(CD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   // Reference model: byte queue plus position inside the current frame.
   logic [7:0] mq[$];
   bit         m_busy = 0;
   int         m_t    = 0;
   logic [7:0] m_cur  = 0;
   bit         m_cmpt = 0;
   bit         m_ovf  = 0;

   task automatic model_step();
      bit full;
      bit empty;
      if (rst) begin
         mq.delete();
         m_busy = 0;
         m_t    = 0;
         m_cmpt = 0;
         m_ovf  = 0;
         return;
      end
      full   = (mq.size() == D);
      empty  = (mq.size() == 0);
      m_ovf  = ifc.wr_en && full;
      m_cmpt = 0;
      if (m_busy) begin
         if (m_t == 0) m_cur = mq.pop_front();
         if (m_t == FR) begin
            if (!empty) begin
               m_t = 0;
            end else begin
               m_busy = 0;
               m_cmpt = 1;
            end
         end else begin
            m_t++;
         end
      end else if (ifc.tx_start && !empty) begin
         m_busy = 1;
         m_t    = 0;
      end
      if (ifc.wr_en && !full) mq.push_back(ifc.wr_data);
   endtask

   function automatic logic m_txd();
      int idx;
      if (!m_busy || m_t == 0) return 1'b1;
      idx = (m_t - 1) / CD;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return m_cur[idx-1];
   endfunction

   initial forever begin
      @(posedge clk);
      model_step();
   end

   function automatic logic [8:0] dut_vec();
      return {ifc.txd, ifc.tx_ting, ifc.tx_cmpt, ifc.txb_empty,
              ifc.txb_full, ifc.wr_ovf, ifc.txb_level};
   endfunction

   always @(negedge clk) begin
      logic [8:0] ev;
      if (chk_en) begin
         ev = {m_txd(), m_busy, m_cmpt, mq.size() == 0,
               mq.size() == D, m_ovf, 3'(mq.size())};
         checks++;
         if (dut_vec() !== ev) begin
            errors++;
            if (nprint < 20) begin
               nprint++;
               $display("FAIL model t=%0t got=%b want=%b",
                        $time, dut_vec(), ev);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic w, input logic [7:0] d, input logic s);
      ifc.wr_en    = w;
      ifc.wr_data  = d;
      ifc.tx_start = s;
      @(posedge clk);
      #1;
      ifc.wr_en    = 1'b0;
      ifc.tx_start = 1'b0;
   endtask

   logic wave[$];

   task automatic run_burst(input int inj, input logic [7:0] inj_d,
                            output int n, output int nc);
      int budget;
      budget = 5000;
      n  = 0;
      nc = 0;
      wave.delete();
      cyc(1'b0, 8'h00, 1'b1);
      while (budget > 0) begin
         if (ifc.tx_cmpt) nc++;
         if (!ifc.tx_ting) break;
         wave.push_back(ifc.txd);
         n++;
         ifc.wr_en    = (n == inj);
         ifc.wr_data  = inj_d;
         ifc.tx_start = (n == inj + 2);
         @(posedge clk);
         #1;
         budget--;
      end
      ifc.wr_en    = 1'b0;
      ifc.tx_start = 1'b0;
      if (budget == 0) begin
         checks++;
         errors++;
         $display("FAIL burst_timeout got=busy want=idle");
      end
      repeat (5) begin
         @(posedge clk);
         #1;
         if (ifc.tx_cmpt) nc++;
      end
   endtask

   task automatic wait_idle(input int budget, output int nc);
      nc = 0;
      while (ifc.tx_ting && budget > 0) begin
         @(posedge clk);
         #1;
         if (ifc.tx_cmpt) nc++;
         budget--;
      end
      if (ifc.tx_ting) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout got=busy want=idle");
      end
   endtask

   function automatic logic [7:0] byte_at(input int k);
      logic [7:0] b;
      int base;
      base = k * (1 + FR);
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
         if (base + 1 + CD * (j + 1) + CD / 2 < wave.size())
            b[j] = wave[base + 1 + CD * (j + 1) + CD / 2];
         else
            b[j] = 1'bx;
      end
      return b;
   endfunction

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       st;
      logic [2:0] lvl;
      logic       full;
      logic       empty;
      logic       ovf;
   } vec_t;

   localparam logic [8:0] RST_VEC = 9'b1_0_0_1_0_0_000;

   initial begin
      vec_t       tbl[6];
      logic       expw[$];
      logic [0:7] seq;
      int         n;
      int         nc;
      int         nt;
      int         mism;

      ifc.wr_en    = 1'b0;
      ifc.wr_data  = 8'h00;
      ifc.tx_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      check("reset_state", 32'(dut_vec()), 32'(RST_VEC));

      nc = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (ifc.tx_cmpt) nc++;
      end
      check("idle_state", 32'(dut_vec()), 32'(RST_VEC));
      check("idle_no_cmpt", nc, 0);

      cyc(1'b1, 8'hA5, 1'b0);
      check("a5_level", ifc.txb_level, 1);
      run_burst(-10, 8'h00, n, nc);
      check("a5_ting_cycles", n, 41);
      check("a5_cmpt", nc, 1);
      seq = 8'b1010_0101;
      expw.push_back(1'b1);
      repeat (CD) expw.push_back(1'b0);
      for (int j = 0; j < 8; j++) repeat (CD) expw.push_back(seq[j]);
      repeat (CD) expw.push_back(1'b1);
      mism = 0;
      for (int i = 0; i < expw.size(); i++)
         if (i >= wave.size() || wave[i] !== expw[i]) mism++;
      check("a5_waveform", mism, 0);
      check("a5_empty", ifc.txb_empty, 1);

      tbl[0] = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'h02, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 8'h03, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 8'h04, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 8'hFF, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         cyc(tbl[i].wr, tbl[i].d, tbl[i].st);
         check($sformatf("fifo_vec%0d", i),
               {ifc.txb_level, ifc.txb_full, ifc.txb_empty, ifc.wr_ovf},
               {tbl[i].lvl, tbl[i].full, tbl[i].empty, tbl[i].ovf});
      end
      run_burst(-10, 8'h00, n, nc);
      check("full_ting_cycles", n, 164);
      check("full_cmpt", nc, 1);
      check("full_bytes", {byte_at(0), byte_at(1), byte_at(2), byte_at(3)},
            32'h01020304);

      cyc(1'b1, 8'h11, 1'b0);
      run_burst(10, 8'h22, n, nc);
      check("append_ting_cycles", n, 82);
      check("append_cmpt", nc, 1);
      check("append_bytes", {byte_at(0), byte_at(1)}, 32'h1122);

      cyc(1'b0, 8'h00, 1'b1);
      nt = 0;
      nc = 0;
      repeat (5) begin
         if (ifc.tx_ting) nt++;
         if (ifc.tx_cmpt) nc++;
         @(posedge clk);
         #1;
      end
      check("empty_start_ting", nt, 0);
      check("empty_start_cmpt", nc, 0);
      cyc(1'b1, 8'hAA, 1'b0);
      cyc(1'b1, 8'hBB, 1'b0);
      check("pushpop_pre_level", ifc.txb_level, 2);
      cyc(1'b0, 8'h00, 1'b1);
      check("pushpop_load_ting", ifc.tx_ting, 1);
      cyc(1'b1, 8'hCC, 1'b0);
      check("pushpop_level", ifc.txb_level, 2);
      wait_idle(1000, nc);
      check("pushpop_cmpt", nc, 1);

      cyc(1'b1, 8'h3C, 1'b0);
      cyc(1'b1, 8'hAA, 1'b0);
      cyc(1'b1, 8'hBB, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      check("midframe_level", ifc.txb_level, 2);
      check("midframe_ting", ifc.tx_ting, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midframe_reset", 32'(dut_vec()), 32'(RST_VEC));
      nt = 0;
      nc = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (ifc.tx_ting) nt++;
         if (ifc.tx_cmpt) nc++;
      end
      check("post_reset_ting", nt, 0);
      check("post_reset_cmpt", nc, 0);

      for (int i = 0; i < 3000; i++) begin
         ifc.wr_en    = ($urandom_range(0, 99) < 10);
         ifc.wr_data  = 8'($urandom);
         ifc.tx_start = ($urandom_range(0, 99) < 5);
         rst          = ($urandom_range(0, 599) == 0);
         @(posedge clk);
         #1;
      end
      ifc.wr_en    = 1'b0;
      ifc.tx_start = 1'b0;
      rst          = 1'b0;
      wait_idle(2000, nc);
      repeat (5) @(posedge clk);
      #1;
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
